// File: rtl/mul_test_pkg.sv
// =====================================================================
// mul_test_pkg : shared field offsets, bounds and retire-op decode
// Rev 1.0
// =====================================================================
`default_nettype none

package mul_test_pkg;

  localparam int IN_VALID_BIT   = 64;
  localparam int IN_ACC_EN_BIT  = 65;
  localparam int IN_ACC_CLR_BIT = 66;

  localparam int OUT_VALID_BIT  = 64;
  localparam int OUT_OVF_BIT    = 65;
  localparam int OUT_CNT_LSB    = 72;

  localparam int RES_W          = 64;
  localparam int CNT_W          = 8;

  localparam int WIDTH_MIN      = 2;
  localparam int WIDTH_MAX      = 32;
  localparam int STAGES_MIN     = 1;
  localparam int STAGES_MAX     = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ACC  = 2'd1,
    OP_CLR  = 2'd2
  } ret_op_e;

  // Clear wins over accumulate so a clear can never see a carry.
  function automatic ret_op_e decode_op(input logic acc_en, input logic acc_clr);
    if (acc_clr)     return OP_CLR;
    else if (acc_en) return OP_ACC;
    else             return OP_LOAD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_pipe.sv
// =====================================================================
// mul_pipe : operand capture register + STAGES-deep product/control pipe
// Rev 1.0
// =====================================================================
`default_nettype none

module mul_pipe
  import mul_test_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 valid_i,
  input  logic                 acc_en_i,
  input  logic                 acc_clr_i,
  output logic [2*WIDTH-1:0]   p_o,
  output logic                 valid_o,
  output logic                 acc_en_o,
  output logic                 acc_clr_o
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mul_pipe: WIDTH out of legal range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mul_pipe: STAGES out of legal range");
  end

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               vld_in_q;
  logic               en_in_q;
  logic               clr_in_q;
  logic [2*WIDTH-1:0] prod_q [STAGES];
  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  en_q;
  logic [STAGES-1:0]  clr_q;
  logic [2*WIDTH-1:0] w_prod;

  // Operands are captured first so the multiplier sits register-to-register.
  assign w_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      vld_in_q <= 1'b0;
      en_in_q  <= 1'b0;
      clr_in_q <= 1'b0;
      vld_q    <= '0;
      en_q     <= '0;
      clr_q    <= '0;
      for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
    end else begin
      a_q       <= a_i;
      b_q       <= b_i;
      vld_in_q  <= valid_i;
      en_in_q   <= acc_en_i;
      clr_in_q  <= acc_clr_i;
      prod_q[0] <= w_prod;
      vld_q[0]  <= vld_in_q;
      en_q[0]   <= en_in_q;
      clr_q[0]  <= clr_in_q;
      for (int i = 1; i < STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        en_q[i]   <= en_q[i-1];
        clr_q[i]  <= clr_q[i-1];
      end
    end
  end

  assign p_o       = prod_q[STAGES-1];
  assign valid_o   = vld_q[STAGES-1];
  assign acc_en_o  = en_q[STAGES-1];
  assign acc_clr_o = clr_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mul_acc_test.sv
// =====================================================================
// mul_acc_test : pipelined multiply-accumulate behind a 128-bit harness bus
// Rev 1.0
// =====================================================================
`default_nettype none

module mul_acc_test
  import mul_test_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] IN,
  output logic [127:0] OUT
);

  localparam int PW = 2 * WIDTH;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mul_acc_test: WIDTH out of legal range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mul_acc_test: STAGES out of legal range");
  end

  logic [PW-1:0]    w_p;
  logic             w_vld;
  logic             w_en;
  logic             w_clr;
  ret_op_e          w_op;
  logic [PW:0]      w_sum;
  logic [RES_W-1:0] w_res_ext;
  logic             w_unused_in;

  logic [PW-1:0]    acc_q,  acc_d;
  logic [PW-1:0]    res_q,  res_d;
  logic             ovf_q,  ovf_d;
  logic             vld_q,  vld_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  mul_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_mul_pipe (
    .clk       (clk),
    .rst       (rst),
    .a_i       (IN[WIDTH-1:0]),
    .b_i       (IN[WIDTH +: WIDTH]),
    .valid_i   (IN[IN_VALID_BIT]),
    .acc_en_i  (IN[IN_ACC_EN_BIT]),
    .acc_clr_i (IN[IN_ACC_CLR_BIT]),
    .p_o       (w_p),
    .valid_o   (w_vld),
    .acc_en_o  (w_en),
    .acc_clr_o (w_clr)
  );

  assign w_unused_in = ^IN;
  assign w_op        = decode_op(w_en, w_clr);
  assign w_sum       = {1'b0, acc_q} + {1'b0, w_p};

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    vld_d = w_vld;
    if (w_vld) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (w_op)
        OP_ACC: begin
          acc_d = w_sum[PW-1:0];
          res_d = w_sum[PW-1:0];
          if (w_sum[PW]) ovf_d = 1'b1;
        end
        OP_CLR: begin
          acc_d = w_p;
          res_d = w_p;
          ovf_d = 1'b0;
        end
        default: res_d = w_p;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // OUT is a pure rewiring of registers, so it changes only on clock edges.
  assign w_res_ext = RES_W'(res_q);

  always_comb begin
    OUT                            = '0;
    OUT[RES_W-1:0]                 = w_res_ext;
    OUT[OUT_VALID_BIT]             = vld_q;
    OUT[OUT_OVF_BIT]               = ovf_q;
    OUT[OUT_CNT_LSB +: CNT_W]      = cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_acc_test.sv
// =====================================================================
// tb_mul_acc_test : directed checks of mul_acc_test (WIDTH=8, STAGES=2)
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_mul_acc_test;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int LAT    = STAGES + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_bus;
  logic [127:0] out_bus;

  int n_vec = 0;
  int n_err = 0;

  mul_acc_test #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .IN  (in_bus),
    .OUT (out_bus)
  );

  always #5 clk = ~clk;

  // {valid, ovf, cnt, result[63:0]}
  logic [73:0] obs;
  assign obs = {out_bus[64], out_bus[65], out_bus[79:72], out_bus[63:0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bits 40 and 100 are junk in ignored fields; they must never matter.
  task automatic drive(input logic v, input logic en, input logic clr,
                       input logic [7:0] a, input logic [7:0] b);
    in_bus        = '0;
    in_bus[40]    = 1'b1;
    in_bus[100]   = 1'b1;
    in_bus[7:0]   = a;
    in_bus[15:8]  = b;
    in_bus[64]    = v;
    in_bus[65]    = en;
    in_bus[66]    = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55);
    step();
    step();
    n_vec++;
    if (out_bus !== 128'd0) begin
      n_err++;
      $display("FAIL reset_out: got %h want 0", out_bus);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_single();
    logic [73:0] exp;
    drive(1'b1, 1'b0, 1'b0, 8'd15, 8'd17);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < LAT; i++) begin
      n_vec++;
      if (out_bus[64] !== 1'b0) begin
        n_err++;
        $display("FAIL single_early[%0d]: valid=%b want 0", i, out_bus[64]);
      end
      step();
    end
    exp = {1'b1, 1'b0, 8'd1, 64'd255};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL single_retire: got %h want %h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 8'd1, 64'd255};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL single_hold: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res_e [3];
    logic        ovf_e [3];
    logic [73:0] exp;
    res_e[0] = 64'd40000; res_e[1] = 64'd14464; res_e[2] = 64'd24464;
    ovf_e[0] = 1'b0;      ovf_e[1] = 1'b1;      ovf_e[2] = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'd200, 8'd200); step();
    drive(1'b1, 1'b1, 1'b0, 8'd200, 8'd200); step();
    drive(1'b1, 1'b1, 1'b0, 8'd100, 8'd100); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {1'b1, ovf_e[i], 8'(2 + i), res_e[i]};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs, exp);
      end
    end
    step();
    n_vec++;
    if (out_bus[64] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_after: valid=%b want 0", out_bus[64]);
    end
  endtask

  task automatic test_clear();
    logic [73:0] exp;
    drive(1'b1, 1'b1, 1'b1, 8'd2, 8'd3);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (LAT) step();
    exp = {1'b1, 1'b0, 8'd5, 64'd6};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL clear: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_load_keeps_acc();
    logic [73:0] exp;
    drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd10); step();
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd1);   step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step();
    step();
    exp = {1'b1, 1'b0, 8'd6, 64'd100};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL load_result: got %h want %h", obs, exp);
    end
    step();
    exp = {1'b1, 1'b0, 8'd7, 64'd7};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL load_keeps_acc: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_cnt_wrap();
    int          pulses;
    logic [73:0] exp;
    pulses = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i), 8'd2);
      step();
      if (out_bus[64] === 1'b1) pulses++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step();
    if (out_bus[64] === 1'b1) pulses++;
    step();
    if (out_bus[64] === 1'b1) pulses++;
    exp = {1'b1, 1'b0, 8'd255, 64'd508};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL cnt_255: got %h want %h", obs, exp);
    end
    step();
    if (out_bus[64] === 1'b1) pulses++;
    exp = {1'b1, 1'b0, 8'd0, 64'd510};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL cnt_wrap0: got %h want %h", obs, exp);
    end
    n_vec++;
    if (pulses !== 256) begin
      n_err++;
      $display("FAIL stream_pulses: got %0d want 256", pulses);
    end
    drive(1'b1, 1'b0, 1'b0, 8'd7, 8'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (LAT) step();
    exp = {1'b1, 1'b0, 8'd1, 64'd63};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL cnt_wrap1: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    drive(1'b1, 1'b0, 1'b0, 8'd9, 8'd9); step();
    drive(1'b1, 1'b1, 1'b0, 8'd4, 8'd4); step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd5);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    n_vec++;
    if (out_bus !== 128'd0) begin
      n_err++;
      $display("FAIL midflight_reset_out: got %h want 0", out_bus);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_bus[64] !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midflight_no_valid: %0d valid cycles, want 0", seen);
    end
    n_vec++;
    if (out_bus !== 128'd0) begin
      n_err++;
      $display("FAIL midflight_idle_out: got %h want 0", out_bus);
    end
  endtask

  task automatic test_hold();
    int          bad;
    logic [73:0] exp;
    bad = 0;
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (LAT) step();
    exp = {1'b1, 1'b0, 8'd1, 64'd65025};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hold_retire: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_bus[64] !== 1'b0 || out_bus[63:0] !== 64'd65025 ||
          out_bus[127:80] !== 48'd0 || out_bus[71:66] !== 6'd0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL hold_idle: %0d bad cycles, want 0 (last OUT %h)", bad, out_bus);
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_bus = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_load_keeps_acc();
    test_cnt_wrap();
    test_reset_midflight();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mul_acc_test.md
MUL_ACC_TEST -- requirements
Module: mul_acc_test

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 2, multiplier pipeline register stages; legal range 1..4.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port IN  input  128  test-harness input bus.
REQ-006 Port OUT  output  128  test-harness output bus, fully registered.
REQ-007 IN field map:
- A = IN[WIDTH-1:0]
- B = IN[2*WIDTH-1:WIDTH]
- in_valid = IN[64]
- acc_en = IN[65]
- acc_clr = IN[66]
- all other IN bits ignored.
REQ-008 OUT field map:
- OUT[63:0] = result, 2*WIDTH bits zero-extended
- OUT[64] = out_valid
- OUT[65] = ovf
- OUT[79:72] = cnt
- all other OUT bits constant 0.

Function
REQ-009 An issue occurs on every rising edge where in_valid=1 and rst=0; A, B, acc_en and acc_clr are sampled together.
REQ-010 The product P = A*B is unsigned, exactly 2*WIDTH bits, no truncation.
REQ-011 P and its sampled controls travel through STAGES register stages, then one output stage; latency is L = STAGES+1 cycles (issue at edge k gives out_valid=1 after edge k+L).
REQ-012 The pipeline is fully pipelined: back-to-back issues every cycle are accepted, with no stall and no backpressure.
REQ-013 out_valid is high for exactly one cycle per issue; with no issue in flight, out_valid=0.
REQ-014 Between valid cycles, result, ovf and cnt hold their last values.
REQ-015 Retiring with acc_en=0, acc_clr=0: result <= P; accumulator unchanged.
REQ-016 Retiring with acc_en=1, acc_clr=0:
- accumulator <= accumulator + P, modulo 2^(2*WIDTH)
- result <= new accumulator value.
REQ-017 Retiring with acc_clr=1 (acc_en ignored):
- accumulator <= P
- result <= P
- ovf <= 0.
REQ-018 ovf is sticky: it sets to 1 when an REQ-016 addition carries out of bit 2*WIDTH-1, and holds until acc_clr retires or rst.
REQ-019 A carry and an acc_clr cannot coincide, because acc_clr suppresses the addition; clear takes priority.
REQ-020 cnt increments by 1 on each retire and wraps 255 -> 0 without flagging.
REQ-021 Retire order equals issue order; each retire uses the accumulator value left by the immediately preceding retire, including back-to-back retires.

Reset
REQ-022 While rst=1 at a rising edge, the following clear to 0: all pipeline valid and data registers, accumulator, result, ovf, cnt and all of OUT.
REQ-023 Reset mid-operation discards every in-flight issue; no out_valid is produced for any issue made before or during reset.
REQ-024 in_valid=1 on the same edge as rst=1 is not an issue.
REQ-025 The first edge with rst=0 may issue; its result appears L cycles later.

Structure
REQ-026 A shared package mul_test_pkg holds:
- IN field offsets (64, 65, 66)
- OUT field offsets (64, 65, 72)
- CNT_W = 8
- legal parameter bounds.
REQ-027 The multiplier and its STAGES-deep valid/control shift pipeline form one sub-module, mul_pipe, parametrised by WIDTH and STAGES; mul_acc_test holds the accumulator, flags, counter and OUT mapping.
REQ-028 Elaboration fails (assertion) if WIDTH or STAGES is outside its legal range.

Verification (WIDTH=8, STAGES=2, L=3)
REQ-029 Reset, then issue A=15, B=17, acc_en=0 at edge k:
- out_valid=1 only after edge k+3
- result=255, cnt=1, ovf=0.
REQ-030 Back-to-back issues (clr, 200*200), (acc, 200*200), (acc, 100*100) on three consecutive edges:
- results 40000, 14464 with ovf=1, 24464 with ovf=1
- out_valid high on 3 consecutive cycles.
REQ-031 Then issue acc_clr=1, A=2, B=3: result=6, ovf=0.
REQ-032 Issue 256 single products: cnt reads 0 after the 256th retire, and 1 after the next.
REQ-033 Issue two products, then assert rst one cycle later for one cycle: no out_valid ever appears for either; OUT=0 after reset.
REQ-034 Issue A=255, B=255, acc_en=0, then hold in_valid=0: result=65025 and OUT[127:80]=0 hold indefinitely with out_valid=0.
